axis_matrix_loader: RTL
=======================

Name: axis_matrix_loader

Overview:
- Receive front end of the matrix coprocessor; sits directly between the AXI-Stream slave port and the A/B/C operand RAMs.
- Accepts one frame of 467 words per job: A (64x7 = 448), then B (8x2 = 16), then C (3).
- Writes the low byte of each word to the correct RAM at the correct address.
- Tells the compute stage when all operands are resident, and holds off further input until compute acknowledges.

Parameters:
WIDTH, 8, payload bits taken from TDATA[WIDTH-1:0]
A_WORDS, 448, A matrix element count
B_WORDS, 16, B matrix element count
C_WORDS, 3, C matrix element count
A_ADDR_BITS, 9, A RAM address width
B_ADDR_BITS, 4, B RAM address width
C_ADDR_BITS, 2, C RAM address width

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESET  in  1  synchronous reset, active-high
S_AXIS_TVALID  in  1  upstream word valid
S_AXIS_TDATA  in  32  upstream word; only [WIDTH-1:0] used
S_AXIS_TLAST  in  1  upstream end-of-frame marker
S_AXIS_TREADY  out  1  loader ready (registered)
A_WEN  out  1  A RAM write enable
A_ADDR  out  A_ADDR_BITS  A RAM write address
A_WDATA  out  WIDTH  A RAM write data
B_WEN / B_ADDR / B_WDATA  out  1 / B_ADDR_BITS / WIDTH  B RAM write port
C_WEN / C_ADDR / C_WDATA  out  1 / C_ADDR_BITS / WIDTH  C RAM write port
load_done  out  1  all operands written; level until load_ack
load_ack  in  1  compute has consumed the operands; re-arms the loader
tlast_err  out  1  sticky TLAST framing error

Behaviour:
- Interface: one clock domain (ACLK). ARESET is synchronous, active-high.
- Reset values: every output is 0; state LOAD_A; all counters 0.
- Ready after reset: S_AXIS_TREADY is 0 while ARESET is high and rises on the first edge after ARESET falls.
- Handshake:
  - A word is accepted on a rising edge where TVALID && TREADY.
  - TREADY never depends combinationally on TVALID.
  - No word is accepted while TREADY is 0.
- States:
  - LOAD_A: accepted word k (0..447) -> A address k. Move to LOAD_B after k = 447.
  - LOAD_B: word j (0..15) -> B address j. Move to LOAD_C after j = 15.
  - LOAD_C: word i (0..2) -> C address i. Move to DONE after i = 2.
  - DONE: TREADY = 0 and no writes. load_ack moves the loader to LOAD_A; counters are cleared.
- Write latency:
  - A handshake at edge n produces xWEN = 1, xADDR and xWDATA = TDATA[7:0] at edge n.
  - These are valid for exactly one cycle, and the RAM commits them at edge n+1.
  - Only one WEN is ever high at a time. WEN = 0 in cycles with no handshake.
  - ADDR and WDATA hold their last values when WEN = 0.
- Final word:
  - The edge accepting C word 2 also clears TREADY, so a 468th word is never accepted.
  - load_done rises one edge after C_WEN for address 2, i.e. after that write has committed.
- load_ack:
  - Honoured only in DONE, and only when load_done = 1. Ignored in all other states.
  - On the edge sampling load_ack: load_done goes to 0, state becomes LOAD_A, and TREADY goes to 1 on the same edge.
- Framing is count-based; TLAST never shortens or extends a frame.
- tlast_err is set if either:
  - TLAST = 1 on an accepted word other than word 466, or
  - TLAST = 0 on accepted word 466.
- tlast_err is cleared only by ARESET.
- Mid-frame TVALID gaps: counters and addresses are held, and resume contiguously with no skipped or repeated address.
- Reset mid-frame: on the next edge everything returns to the reset values. The partial RAM contents are not signalled as valid, and the next frame starts at A address 0.
- Simultaneous ARESET and load_ack: reset wins.

Test Plan:
- Continuous frame, TVALID held high, TDATA = word index, TLAST on word 466:
  - A writes addr 0..447 with data 0x00..0xFF, then 0x00..0xBF.
  - B writes addr 0..15 with data 0xC0..0xCF.
  - C writes addr 0..2 with data 0xD0..0xD2.
  - load_done = 1 one cycle after the last C_WEN; TREADY = 0 from the final acceptance; tlast_err = 0.
- TVALID dropped for one cycle after word 2, and for two cycles at the A->B boundary:
  - No WEN during the gaps.
  - A addr 3 follows addr 2; B addr 0 receives word 448.
- TDATA upper bits = 0xDEADBE, low byte = 0x5A:
  - WDATA = 0x5A.
- TLAST asserted on word 100 and again on word 466:
  - tlast_err = 1 from the edge after word 100; the frame still completes with 467 writes.
- Back-to-back frames with TLAST absent on word 466 in frame 1:
  - tlast_err = 1.
  - TVALID held high in DONE for 5 cycles -> no writes, TREADY stays 0.
  - load_ack for 1 cycle -> TREADY = 1 on the next edge; frame 2 writes A addr 0 first.
- ARESET for 1 cycle after word 200:
  - All outputs 0, TREADY 0 during reset, then 1.
  - The next accepted word goes to A addr 0; load_done never asserted for the aborted frame.

Source files
------------

// File: rtl/axis_matrix_loader.sv
// AXI-Stream receive front end: scatters one fixed-length frame into the A/B/C
// operand RAMs, then holds the stream off until compute acknowledges the load.
module axis_matrix_loader #(
  parameter int WIDTH       = 8,
  parameter int A_WORDS     = 448,
  parameter int B_WORDS     = 16,
  parameter int C_WORDS     = 3,
  parameter int A_ADDR_BITS = 9,
  parameter int B_ADDR_BITS = 4,
  parameter int C_ADDR_BITS = 2
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   S_AXIS_TVALID,
  input  logic [31:0]            S_AXIS_TDATA,
  input  logic                   S_AXIS_TLAST,
  output logic                   S_AXIS_TREADY,
  output logic                   A_WEN,
  output logic [A_ADDR_BITS-1:0] A_ADDR,
  output logic [WIDTH-1:0]       A_WDATA,
  output logic                   B_WEN,
  output logic [B_ADDR_BITS-1:0] B_ADDR,
  output logic [WIDTH-1:0]       B_WDATA,
  output logic                   C_WEN,
  output logic [C_ADDR_BITS-1:0] C_ADDR,
  output logic [WIDTH-1:0]       C_WDATA,
  output logic                   load_done,
  input  logic                   load_ack,
  output logic                   tlast_err
);

  // One shared element counter sized for the largest matrix
  localparam int CNT_BITS = A_ADDR_BITS;

  typedef enum logic [1:0] {LOAD_A, LOAD_B, LOAD_C, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] cnt, cnt_nxt;
  logic                accept;
  logic                last_word;
  logic                ack_take;
  logic                unused_tdata;

  assign unused_tdata = ^S_AXIS_TDATA[31:WIDTH];
  assign accept       = S_AXIS_TVALID && S_AXIS_TREADY;
  assign last_word    = (state == LOAD_C) && (cnt == CNT_BITS'(C_WORDS - 1));
  assign ack_take     = (state == DONE) && load_done && load_ack;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      LOAD_A: if (accept) begin
        if (cnt == CNT_BITS'(A_WORDS - 1)) begin
          state_nxt = LOAD_B;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_BITS'(1);
        end
      end
      LOAD_B: if (accept) begin
        if (cnt == CNT_BITS'(B_WORDS - 1)) begin
          state_nxt = LOAD_C;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_BITS'(1);
        end
      end
      LOAD_C: if (accept) begin
        if (last_word) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_BITS'(1);
        end
      end
      DONE: if (ack_take) begin
        state_nxt = LOAD_A;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = LOAD_A;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Ready is registered from the next state, so the final C word drops it on
  // the same edge and a stray extra word can never be taken
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state         <= LOAD_A;
      cnt           <= '0;
      S_AXIS_TREADY <= 1'b0;
      A_WEN         <= 1'b0;
      A_ADDR        <= '0;
      A_WDATA       <= '0;
      B_WEN         <= 1'b0;
      B_ADDR        <= '0;
      B_WDATA       <= '0;
      C_WEN         <= 1'b0;
      C_ADDR        <= '0;
      C_WDATA       <= '0;
      load_done     <= 1'b0;
      tlast_err     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      S_AXIS_TREADY <= (state_nxt != DONE);
      A_WEN         <= accept && (state == LOAD_A);
      B_WEN         <= accept && (state == LOAD_B);
      C_WEN         <= accept && (state == LOAD_C);
      if (accept && (state == LOAD_A)) begin
        A_ADDR  <= cnt[A_ADDR_BITS-1:0];
        A_WDATA <= S_AXIS_TDATA[WIDTH-1:0];
      end
      if (accept && (state == LOAD_B)) begin
        B_ADDR  <= cnt[B_ADDR_BITS-1:0];
        B_WDATA <= S_AXIS_TDATA[WIDTH-1:0];
      end
      if (accept && (state == LOAD_C)) begin
        C_ADDR  <= cnt[C_ADDR_BITS-1:0];
        C_WDATA <= S_AXIS_TDATA[WIDTH-1:0];
      end
      // Done follows the last C write by one edge, once that write has committed
      if (ack_take) begin
        load_done <= 1'b0;
      end else if (state == DONE) begin
        load_done <= 1'b1;
      end
      if (accept && (S_AXIS_TLAST != last_word)) begin
        tlast_err <= 1'b1;
      end
    end
  end

endmodule
